// File: rtl/wash_sequencer.sv
// Washing-machine cycle sequencer: soap wash, RINSE_COUNT rinse passes, then spin,
// with fill/drain watchdogs, a pause input and a latched fault state.
module wash_sequencer #(
  parameter int RINSE_COUNT = 2,
  parameter int CNT_W       = 16,
  parameter int WASH_TICKS  = 1000,
  parameter int RINSE_TICKS = 500,
  parameter int SPIN_TICKS  = 300,
  parameter int FILL_LIMIT  = 2000,
  parameter int DRAIN_LIMIT = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       door_close,
  input  logic       filled,
  input  logic       drained,
  input  logic       detergent_added,
  input  logic       pause,
  output logic       door_lock,
  output logic       motor_on,
  output logic       fill_valve_on,
  output logic       drain_valve_on,
  output logic       soap_wash,
  output logic       water_wash,
  output logic       done,
  output logic       fault,
  output logic [2:0] rinse_idx,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_DETERGENT = 3'd2,
    S_WASH      = 3'd3,
    S_DRAIN     = 3'd4,
    S_SPIN      = 3'd5,
    S_DONE      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_TICKS - 1);
  localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_TICKS - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_LIMIT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LIMIT - 1);
  localparam logic [2:0]       RINSE_MAX  = 3'(RINSE_COUNT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rinse_q, rinse_d;
  logic [CNT_W-1:0] wash_last;
  logic             locked;
  logic             paused;

  always_comb begin
    state_d   = state_q;
    rinse_d   = rinse_q;
    locked    = state_q inside {S_FILL, S_DETERGENT, S_WASH, S_DRAIN, S_SPIN};
    paused    = pause && (state_q inside {S_FILL, S_WASH, S_DRAIN, S_SPIN});
    wash_last = (rinse_q == 3'd0) ? WASH_LAST : RINSE_LAST;

    // An open door while locked overrides every other exit, paused or not.
    if (locked && !door_close) begin
      state_d = S_FAULT;
    end else if (!paused) begin
      case (state_q)
        S_IDLE: if (start && door_close) begin
          state_d = S_FILL;
          rinse_d = 3'd0;
        end
        S_FILL: begin
          if (filled) state_d = (rinse_q == 3'd0) ? S_DETERGENT : S_WASH;
          else if (cnt_q == FILL_LAST) state_d = S_FAULT;
        end
        S_DETERGENT: if (detergent_added) state_d = S_WASH;
        S_WASH: if (cnt_q == wash_last) state_d = S_DRAIN;
        S_DRAIN: begin
          if (drained) begin
            if (rinse_q < RINSE_MAX) begin
              rinse_d = rinse_q + 3'd1;
              state_d = S_FILL;
            end else begin
              state_d = S_SPIN;
            end
          end else if (cnt_q == DRAIN_LAST) begin
            state_d = S_FAULT;
          end
        end
        S_SPIN: if (cnt_q == SPIN_LAST) state_d = S_DONE;
        S_DONE: if (!start) state_d = S_IDLE;
        default: state_d = S_FAULT;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
    else if (paused || (cnt_q == '1)) cnt_d = cnt_q;
    else cnt_d = cnt_q + 1'b1;
  end

  // Outputs are registered from the next state so they change together with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      rinse_q        <= 3'd0;
      door_lock      <= 1'b0;
      motor_on       <= 1'b0;
      fill_valve_on  <= 1'b0;
      drain_valve_on <= 1'b0;
      soap_wash      <= 1'b0;
      water_wash     <= 1'b0;
      done           <= 1'b0;
      fault          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rinse_q        <= rinse_d;
      door_lock      <= state_d inside {S_FILL, S_DETERGENT, S_WASH, S_DRAIN, S_SPIN};
      motor_on       <= (state_d inside {S_WASH, S_SPIN}) && !paused;
      fill_valve_on  <= (state_d == S_FILL) && !paused;
      drain_valve_on <= (state_d inside {S_DRAIN, S_SPIN}) && !paused;
      soap_wash      <= (state_d inside {S_DETERGENT, S_WASH, S_DRAIN}) && (rinse_d == 3'd0);
      water_wash     <= (state_d inside {S_FILL, S_WASH, S_DRAIN}) && (rinse_d != 3'd0);
      done           <= (state_d == S_DONE);
      fault          <= (state_d == S_FAULT);
    end
  end

  assign rinse_idx   = rinse_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: randomized sensor response delays and pause placement,
// checked against phase lengths and sequences derived from the cycle rules.
module tb_wash_sequencer;

  localparam int RC = 2;
  localparam int WT = 4;
  localparam int RT = 3;
  localparam int ST = 2;
  localparam int FL = 8;
  localparam int DL = 8;

  logic       clock, reset;
  logic       start, door_close, filled, drained, detergent_added, pause;
  logic       door_lock, motor_on, fill_valve_on, drain_valve_on;
  logic       soap_wash, water_wash, done, fault;
  logic [2:0] rinse_idx, dbg_state;

  int tests_run = 0;
  int failures  = 0;

  int fill_cnt, fill_need, det_cnt, det_need, drn_cnt, drn_need;

  wash_sequencer #(
    .RINSE_COUNT(RC), .CNT_W(16), .WASH_TICKS(WT), .RINSE_TICKS(RT),
    .SPIN_TICKS(ST), .FILL_LIMIT(FL), .DRAIN_LIMIT(DL)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .door_close(door_close),
    .filled(filled), .drained(drained), .detergent_added(detergent_added),
    .pause(pause), .door_lock(door_lock), .motor_on(motor_on),
    .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
    .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
    .fault(fault), .rinse_idx(rinse_idx), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    start = 0; door_close = 0; filled = 0; drained = 0; detergent_added = 0; pause = 0;
    fill_cnt = 0; det_cnt = 0; drn_cnt = 0;
    fill_need = $urandom_range(1, 3);
    det_need  = $urandom_range(1, 3);
    drn_need  = $urandom_range(1, 3);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- driver: sensors answer each request after a random delay ----------------
  task automatic service();
    if (fill_valve_on) begin
      fill_cnt++;
      filled = (fill_cnt >= fill_need);
    end else begin
      fill_cnt = 0; filled = 0; fill_need = $urandom_range(1, 3);
    end
    if (soap_wash && door_lock && !motor_on && !drain_valve_on && !fill_valve_on) begin
      det_cnt++;
      detergent_added = (det_cnt >= det_need);
    end else begin
      det_cnt = 0; detergent_added = 0; det_need = $urandom_range(1, 3);
    end
    if (drain_valve_on && !motor_on) begin
      drn_cnt++;
      drained = (drn_cnt >= drn_need);
    end else begin
      drn_cnt = 0; drained = 0; drn_need = $urandom_range(1, 3);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    start = 1; door_close = 1; filled = 0; drained = 0; detergent_added = 0; pause = 0;
    #3;
    tests_run++;
    if ({door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash, water_wash,
         done, fault, rinse_idx} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs got %b want 0", {door_lock, motor_on, fill_valve_on,
               drain_valve_on, soap_wash, water_wash, done, fault, rinse_idx});
    end
    repeat (3) step();
    tests_run++;
    if ({door_lock, fill_valve_on, done, fault} !== 4'd0) begin
      failures++;
      $display("FAIL reset_held got %b want 0", {door_lock, fill_valve_on, done, fault});
    end
  endtask

  task automatic test_full_cycle();
    logic [15:0] exp_q[$];
    logic [15:0] run_q[$];
    logic [2:0]  exp_r[$];
    logic [2:0]  got_r[$];
    int run, fills, soap_motor, water_motor;
    bit reached, prev_fill;
    apply_reset();
    exp_q.push_back(16'(WT));
    for (int i = 0; i < RC; i++) exp_q.push_back(16'(RT));
    exp_q.push_back(16'(ST));
    for (int i = 0; i <= RC; i++) exp_r.push_back(3'(i));
    start = 1; door_close = 1;
    run = 0; fills = 0; soap_motor = 0; water_motor = 0; reached = 0; prev_fill = 0;
    for (int t = 0; t < 300; t++) begin
      step();
      if (motor_on) run++;
      else if (run > 0) begin run_q.push_back(16'(run)); run = 0; end
      if (motor_on && soap_wash) soap_motor++;
      if (motor_on && water_wash) water_motor++;
      if (fill_valve_on && !prev_fill) fills++;
      prev_fill = fill_valve_on;
      if (door_lock && (got_r.size() == 0 || got_r[$] != rinse_idx)) got_r.push_back(rinse_idx);
      if (done) begin reached = 1; break; end
      service();
    end
    tests_run++;
    if (!reached) begin
      failures++;
      $display("FAIL full_done_timeout got done=%0b want 1", done);
    end
    tests_run++;
    if (door_lock !== 1'b0 || motor_on !== 1'b0) begin
      failures++;
      $display("FAIL full_done_unlocked got lock=%0b motor=%0b want 0 0", door_lock, motor_on);
    end
    tests_run++;
    if (run_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL full_motor_runs_count got %0d want %0d", run_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (run_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL full_motor_run%0d got %0d want %0d", i, run_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (got_r != exp_r) begin
      failures++;
      $display("FAIL full_rinse_seq got %p want %p", got_r, exp_r);
    end
    tests_run++;
    if (fills !== RC + 1) begin
      failures++;
      $display("FAIL full_fill_count got %0d want %0d", fills, RC + 1);
    end
    tests_run++;
    if (soap_motor !== WT || water_motor !== RT * RC) begin
      failures++;
      $display("FAIL full_phase_motor got soap=%0d water=%0d want %0d %0d",
               soap_motor, water_motor, WT, RT * RC);
    end
  endtask

  task automatic test_level_start();
    // continues from DONE with start still high
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (done !== 1'b1 || fill_valve_on !== 1'b0 || door_lock !== 1'b0) begin
        failures++;
        $display("FAIL level_hold got done=%0b fill=%0b lock=%0b want 1 0 0",
                 done, fill_valve_on, door_lock);
      end
    end
    start = 0;
    step();
    tests_run++;
    if (done !== 1'b0 || door_lock !== 1'b0) begin
      failures++;
      $display("FAIL level_drop got done=%0b lock=%0b want 0 0", done, door_lock);
    end
    start = 1;
    step();
    tests_run++;
    if (fill_valve_on !== 1'b1 || rinse_idx !== 3'd0) begin
      failures++;
      $display("FAIL level_restart got fill=%0b rinse=%0d want 1 0", fill_valve_on, rinse_idx);
    end
  endtask

  task automatic test_pause();
    int first, motor_seen, drain_at, k, t;
    bit pause_done;
    apply_reset();
    start = 1; door_close = 1;
    k = $urandom_range(1, 3);
    first = -1; motor_seen = 0; drain_at = -1; pause_done = 0; t = 0;
    while (t < 300 && drain_at < 0) begin
      step(); t++;
      if (motor_on && first < 0) first = t;
      if (motor_on) motor_seen++;
      if (drain_valve_on && first >= 0) begin drain_at = t; break; end
      if (first >= 0 && motor_seen == k && !pause_done) begin
        pause = 1;
        for (int p = 0; p < 5; p++) begin
          step(); t++;
          tests_run++;
          if (motor_on !== 1'b0 || door_lock !== 1'b1) begin
            failures++;
            $display("FAIL pause_motor_off cyc%0d got motor=%0b lock=%0b want 0 1",
                     p, motor_on, door_lock);
          end
        end
        pause = 0; pause_done = 1;
      end
      service();
    end
    tests_run++;
    if (drain_at < 0 || (drain_at - first) !== WT + 5) begin
      failures++;
      $display("FAIL pause_wash_len got %0d want %0d", drain_at - first, WT + 5);
    end
    tests_run++;
    if (motor_seen !== WT) begin
      failures++;
      $display("FAIL pause_motor_cycles got %0d want %0d", motor_seen, WT);
    end
  endtask

  task automatic test_fill_watchdog();
    int f, ft;
    apply_reset();
    start = 1; door_close = 1;
    f = -1; ft = -1;
    for (int t = 0; t < 100; t++) begin
      step();
      if (fill_valve_on && f < 0) f = t;
      if (fault) begin ft = t; break; end
    end
    tests_run++;
    if (ft < 0 || f < 0 || (ft - f) !== FL) begin
      failures++;
      $display("FAIL fill_wd_delay got %0d want %0d", ft - f, FL);
    end
    tests_run++;
    if ({door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash, water_wash, done} !== 7'd0) begin
      failures++;
      $display("FAIL fill_wd_outputs got %b want 0", {door_lock, motor_on, fill_valve_on,
               drain_valve_on, soap_wash, water_wash, done});
    end
    start = 0; filled = 1;
    repeat (4) step();
    tests_run++;
    if (fault !== 1'b1) begin
      failures++;
      $display("FAIL fill_wd_latched got %0b want 1", fault);
    end
  endtask

  task automatic test_door_open();
    int r;
    bit hit;
    apply_reset();
    r = $urandom_range(1, RC);
    start = 1; door_close = 1; hit = 0;
    for (int t = 0; t < 300; t++) begin
      step();
      if (drain_valve_on && !motor_on && rinse_idx == 3'(r)) begin hit = 1; break; end
      service();
    end
    door_close = 0; drained = 0;
    step();
    tests_run++;
    if (!hit || fault !== 1'b1 || drain_valve_on !== 1'b0 || door_lock !== 1'b0) begin
      failures++;
      $display("FAIL door_open got hit=%0b fault=%0b drain=%0b lock=%0b want 1 1 0 0",
               hit, fault, drain_valve_on, door_lock);
    end
  endtask

  task automatic test_reset_mid_spin();
    bit hit;
    apply_reset();
    start = 1; door_close = 1; hit = 0;
    for (int t = 0; t < 300; t++) begin
      step();
      if (motor_on && drain_valve_on) begin hit = 1; break; end
      service();
    end
    #2 reset = 0;
    #1;
    tests_run++;
    if (!hit || {door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash, water_wash,
                 done, fault, rinse_idx} !== 11'd0) begin
      failures++;
      $display("FAIL spin_reset got hit=%0b outs=%b want 1 0", hit, {door_lock, motor_on,
               fill_valve_on, drain_valve_on, soap_wash, water_wash, done, fault, rinse_idx});
    end
    filled = 0; drained = 0; detergent_added = 0; pause = 0;
    start = 1; door_close = 1;
    #1 reset = 1;
    step();
    tests_run++;
    if (fill_valve_on !== 1'b1 || rinse_idx !== 3'd0 || door_lock !== 1'b1) begin
      failures++;
      $display("FAIL spin_reset_restart got fill=%0b rinse=%0d lock=%0b want 1 0 1",
               fill_valve_on, rinse_idx, door_lock);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_cycle();
    test_level_start();
    test_pause();
    test_fill_watchdog();
    test_door_open();
    test_reset_mid_spin();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Parametrised washing-machine cycle sequencer. It runs one soap wash, then a configurable number of rinse passes, then a spin. Wash, rinse and spin durations come from internal cycle counters rather than external timeout strobes. Fill and drain have watchdog limits, and the block has a pause input and a latched fault state. It sits between the front-panel/sensor inputs and the valve, motor and lock actuator drivers.

## Interface
- RINSE_COUNT, 2: rinse passes after the soap wash; legal range 1..7.
- CNT_W, 16: width of the shared phase counter.
- WASH_TICKS, 1000: motor cycles in the soap wash; must be at least 1 and fit in CNT_W.
- RINSE_TICKS, 500: motor cycles per rinse pass; must be at least 1.
- SPIN_TICKS, 300: motor cycles in the spin; must be at least 1.
- FILL_LIMIT, 2000: maximum cycles in FILL before a fault is raised.
- DRAIN_LIMIT, 2000: maximum cycles in DRAIN before a fault is raised.

Ports (name, direction, width, meaning):
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets the block.
- start  in  1  level request to run a cycle.
- door_close  in  1  door sensor; 1 means the door is closed.
- filled  in  1  water-level-full sensor.
- drained  in  1  water-level-empty sensor.
- detergent_added  in  1  detergent dispensed acknowledge.
- pause  in  1  level; freezes timers and actuators.
- door_lock  out  1  door lock solenoid.
- motor_on  out  1  drum motor.
- fill_valve_on  out  1  inlet valve.
- drain_valve_on  out  1  drain pump/valve.
- soap_wash  out  1  soap phase active.
- water_wash  out  1  rinse phase active.
- done  out  1  cycle complete.
- fault  out  1  latched fault.
- rinse_idx  out  3  number of rinse passes started so far, 0..RINSE_COUNT.

## Operation
States and transitions:
- IDLE: leaves when start=1 and door_close=1; goes to FILL and clears rinse_idx.
- FILL: leaves on filled=1.
  - If rinse_idx=0, goes to DETERGENT.
  - Otherwise goes to WASH.
- DETERGENT: goes to WASH on detergent_added=1.
- WASH: leaves when the counter reaches its limit and goes to DRAIN.
  - Limit is WASH_TICKS-1 when rinse_idx=0.
  - Limit is RINSE_TICKS-1 otherwise.
- DRAIN: leaves on drained=1.
  - If rinse_idx<RINSE_COUNT, increments rinse_idx and goes to FILL.
  - Otherwise goes to SPIN.
- SPIN: goes to DONE when the counter reaches SPIN_TICKS-1.
- DONE: goes to IDLE when start=0.
- FAULT: terminal; the only exit is reset.

Outputs are Moore outputs decoded from the registered state only; there is no combinational path from any input to any output. Output values per state:
- door_lock=1 in every state except IDLE, DONE and FAULT.
- fill_valve_on=1 in FILL.
- motor_on=1 in WASH and SPIN.
- drain_valve_on=1 in DRAIN and SPIN.
- soap_wash=1 in DETERGENT, WASH and DRAIN while rinse_idx=0.
- water_wash=1 in FILL, WASH and DRAIN while rinse_idx>0.
- done=1 only in DONE.
- fault=1 only in FAULT.
- In FAULT all actuator outputs are 0.

Pause behaviour:
- While pause=1 in FILL, WASH, DRAIN or SPIN, the state holds and the counter holds.
- motor_on, fill_valve_on and drain_valve_on are forced to 0 during pause; door_lock stays 1.
- Pause has no effect in IDLE, DETERGENT, DONE and FAULT.

Fault conditions:
- Entering FAULT on any of these conditions takes priority over every other transition in the same cycle.
- FILL counter reaches FILL_LIMIT-1 with filled=0.
- DRAIN counter reaches DRAIN_LIMIT-1 with drained=0.
- door_close=0 in any state where door_lock=1.

Counter rules:
- The phase counter clears to 0 on every state change.
- It increments by 1 per unpaused cycle and saturates; it never wraps.

## Timing
- Reset asserted: state=IDLE, counter=0, rinse_idx=0, and every output is 0, all immediately and asynchronously. Reset mid-cycle abandons the cycle with no completion.
- Any transition is registered on the rising edge where its condition is sampled true; outputs follow in the same cycle as the new state.
- Unpaused WASH lasts exactly WASH_TICKS cycles; each rinse WASH lasts exactly RINSE_TICKS cycles; SPIN lasts exactly SPIN_TICKS cycles. Each cycle with pause=1 adds exactly one cycle to the phase.
- start is level-sensitive. start held high in DONE keeps done=1; no auto-restart happens until start has been low for at least one cycle.
- filled and drained are sampled only in their own states.
- Simultaneous fault and normal exit (for example filled=1 and door_close=0 in the same cycle): FAULT wins.

## Test plan
Use WASH_TICKS=4, RINSE_TICKS=3, SPIN_TICKS=2, RINSE_COUNT=2 and FILL_LIMIT=DRAIN_LIMIT=8 for all scenarios.
- Full cycle, sensors acknowledged one cycle after each request:
  - motor_on pulses high for 4 cycles, then 3, then 3, then 2 (spin).
  - rinse_idx steps 0→1→2.
  - done=1 is reached with door_lock=0.
- Pause: pause=1 for 5 cycles in the middle of the soap WASH → motor_on=0 for those 5 cycles, and WASH lasts 9 cycles in total.
- Fill watchdog: filled held at 0 → fault=1 exactly 8 cycles after FILL is entered, with all actuators 0; only reset clears it.
- Door opened while locked: door_close dropped during a rinse DRAIN → FAULT on the next edge and drain_valve_on=0.
- Reset mid-operation: reset=0 during SPIN → all outputs 0 immediately. After reset is released with start=1 and door_close=1, FILL is entered with rinse_idx=0.
- Level start: start held at 1 through DONE → done stays 1 and no restart occurs. Dropping start returns the block to IDLE within 1 cycle.
